// File: rtl/qpu_exu_alu_wbck.sv
// ALU write-back stage: small in-order FIFO retiring results to either the
// classical register file port or the timing register port.
module qpu_exu_alu_wbck #(
  parameter int XLEN       = 32,
  parameter int TIME_WIDTH = 16,
  parameter int RFIDX_W    = 5,
  parameter int DEPTH      = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wbck_i_valid,
  output logic                     wbck_i_ready,
  input  logic [XLEN-1:0]          wbck_i_cdata,
  input  logic [RFIDX_W-1:0]       wbck_i_rdidx,
  input  logic                     wbck_i_rdwen,
  input  logic                     wbck_i_dtime,
  input  logic                     wbck_flush,
  output logic                     rf_wbck_valid,
  input  logic                     rf_wbck_ready,
  output logic [RFIDX_W-1:0]       rf_wbck_idx,
  output logic [XLEN-1:0]          rf_wbck_data,
  output logic                     time_wbck_valid,
  input  logic                     time_wbck_ready,
  output logic [TIME_WIDTH-1:0]    time_wbck_data,
  output logic [$clog2(DEPTH):0]   wbck_cnt,
  output logic                     wbck_idle
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [XLEN-1:0]    cdata_mem [DEPTH];
  logic [RFIDX_W-1:0] rdidx_mem [DEPTH];
  logic [DEPTH-1:0]   rdwen_mem;
  logic [DEPTH-1:0]   dtime_mem;

  logic [CW-1:0] count_reg, count_next;
  logic [PW-1:0] rd_ptr_reg, rd_ptr_next;
  logic [PW-1:0] wr_ptr_reg, wr_ptr_next;

  logic full, empty, push, pop;
  logic head_drop, head_time, head_rf;
  logic [XLEN-1:0]    head_cdata;
  logic [RFIDX_W-1:0] head_rdidx;
  logic               head_rdwen, head_dtime;

  // Ready comes from the registered count alone, so it never waits on the write ports.
  assign full         = (count_reg == CW'(DEPTH));
  assign empty        = (count_reg == '0);
  assign wbck_i_ready = !full;
  assign push         = wbck_i_valid && wbck_i_ready;

  assign head_cdata = cdata_mem[rd_ptr_reg];
  assign head_rdidx = rdidx_mem[rd_ptr_reg];
  assign head_rdwen = rdwen_mem[rd_ptr_reg];
  assign head_dtime = dtime_mem[rd_ptr_reg];

  // Writes to x0 and non-writing results retire silently.
  assign head_drop = !empty && (!head_rdwen || (!head_dtime && (head_rdidx == '0)));
  assign head_time = !empty && head_rdwen && head_dtime;
  assign head_rf   = !empty && !head_drop && !head_time;

  assign pop = head_drop
            || (head_time && time_wbck_ready)
            || (head_rf && rf_wbck_ready);

  assign rf_wbck_valid   = head_rf;
  assign rf_wbck_idx     = head_rf ? head_rdidx : '0;
  assign rf_wbck_data    = head_rf ? head_cdata : '0;
  assign time_wbck_valid = head_time;
  assign time_wbck_data  = head_time ? head_cdata[TIME_WIDTH-1:0] : '0;
  assign wbck_cnt        = count_reg;
  assign wbck_idle       = empty;

  always_comb begin
    count_next  = count_reg;
    rd_ptr_next = rd_ptr_reg;
    wr_ptr_next = wr_ptr_reg;
    if (wbck_flush) begin
      count_next  = '0;
      rd_ptr_next = '0;
      wr_ptr_next = '0;
    end else begin
      if (push) begin
        wr_ptr_next = (wr_ptr_reg == PW'(DEPTH - 1)) ? '0 : wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_next = (rd_ptr_reg == PW'(DEPTH - 1)) ? '0 : rd_ptr_reg + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_next = count_reg + 1'b1;
        2'b01:   count_next = count_reg - 1'b1;
        default: count_next = count_reg;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg  <= '0;
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
    end else begin
      count_reg  <= count_next;
      rd_ptr_reg <= rd_ptr_next;
      wr_ptr_reg <= wr_ptr_next;
    end
  end

  // Payload storage needs no reset: entries are only visible while counted.
  always_ff @(posedge clk) begin
    if (push) begin
      cdata_mem[wr_ptr_reg] <= wbck_i_cdata;
      rdidx_mem[wr_ptr_reg] <= wbck_i_rdidx;
      rdwen_mem[wr_ptr_reg] <= wbck_i_rdwen;
      dtime_mem[wr_ptr_reg] <= wbck_i_dtime;
    end
  end

endmodule

// File: tb/tb_qpu_exu_alu_wbck.sv
// Bench for qpu_exu_alu_wbck: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_qpu_exu_alu_wbck;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wbck_i_valid;
  logic        wbck_i_ready;
  logic [31:0] wbck_i_cdata;
  logic [4:0]  wbck_i_rdidx;
  logic        wbck_i_rdwen;
  logic        wbck_i_dtime;
  logic        wbck_flush;
  logic        rf_wbck_valid;
  logic        rf_wbck_ready;
  logic [4:0]  rf_wbck_idx;
  logic [31:0] rf_wbck_data;
  logic        time_wbck_valid;
  logic        time_wbck_ready;
  logic [15:0] time_wbck_data;
  logic [1:0]  wbck_cnt;
  logic        wbck_idle;

  qpu_exu_alu_wbck #(.XLEN(32), .TIME_WIDTH(16), .RFIDX_W(5), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .wbck_i_valid(wbck_i_valid), .wbck_i_ready(wbck_i_ready),
    .wbck_i_cdata(wbck_i_cdata), .wbck_i_rdidx(wbck_i_rdidx),
    .wbck_i_rdwen(wbck_i_rdwen), .wbck_i_dtime(wbck_i_dtime),
    .wbck_flush(wbck_flush),
    .rf_wbck_valid(rf_wbck_valid), .rf_wbck_ready(rf_wbck_ready),
    .rf_wbck_idx(rf_wbck_idx), .rf_wbck_data(rf_wbck_data),
    .time_wbck_valid(time_wbck_valid), .time_wbck_ready(time_wbck_ready),
    .time_wbck_data(time_wbck_data),
    .wbck_cnt(wbck_cnt), .wbck_idle(wbck_idle)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] cdata;
    logic [4:0]  rdidx;
    logic        rdwen;
    logic        dtime;
  } ent_t;

  ent_t q[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // One clock: compare against the model at the falling edge, advance the model,
  // then return 1 time unit after the rising edge so the caller can drive inputs.
  task automatic step();
    bit e_rfv, e_tv, drop, e_push, e_pop;
    ent_t h, n;
    e_rfv = 0; e_tv = 0; drop = 0;
    @(negedge clk);
    if (q.size() > 0) begin
      h = q[0];
      if (!h.rdwen || (!h.dtime && h.rdidx == 5'd0)) drop = 1;
      else if (h.dtime) e_tv = 1;
      else e_rfv = 1;
    end
    chk("i_ready", 64'(wbck_i_ready), 64'(q.size() < DEPTH));
    chk("cnt", 64'(wbck_cnt), 64'(q.size()));
    chk("idle", 64'(wbck_idle), 64'(q.size() == 0));
    chk("rf_valid", 64'(rf_wbck_valid), 64'(e_rfv));
    chk("time_valid", 64'(time_wbck_valid), 64'(e_tv));
    if (e_rfv) begin
      chk("rf_idx", 64'(rf_wbck_idx), 64'(h.rdidx));
      chk("rf_data", 64'(rf_wbck_data), 64'(h.cdata));
    end
    if (e_tv) chk("time_data", 64'(time_wbck_data), 64'(h.cdata[15:0]));

    e_push = wbck_i_valid && (q.size() < DEPTH);
    e_pop  = drop || (e_tv && time_wbck_ready) || (e_rfv && rf_wbck_ready);
    if (e_pop) begin
      if (drop)      $display("retire DROP idx=%0d", h.rdidx);
      else if (e_tv) $display("retire TIME data=%h", h.cdata[15:0]);
      else           $display("retire RF idx=%0d data=%h", h.rdidx, h.cdata);
    end
    if (wbck_flush) begin
      q.delete();
    end else begin
      if (e_pop) void'(q.pop_front());
      if (e_push) begin
        n.cdata = wbck_i_cdata; n.rdidx = wbck_i_rdidx;
        n.rdwen = wbck_i_rdwen; n.dtime = wbck_i_dtime;
        q.push_back(n);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] d, input logic [4:0] idx,
                       input logic wen, input logic dt);
    wbck_i_valid = v; wbck_i_cdata = d; wbck_i_rdidx = idx;
    wbck_i_rdwen = wen; wbck_i_dtime = dt;
  endtask

  initial begin
    rst_n = 1'b0;
    wbck_flush = 0; rf_wbck_ready = 1; time_wbck_ready = 1;
    drive(0, 32'd0, 5'd0, 0, 0);
    #3;
    chk("rst_rf_valid", 64'(rf_wbck_valid), 64'd0);
    chk("rst_time_valid", 64'(time_wbck_valid), 64'd0);
    chk("rst_ready", 64'(wbck_i_ready), 64'd1);
    chk("rst_idle", 64'(wbck_idle), 64'd1);
    chk("rst_cnt", 64'(wbck_cnt), 64'd0);
    chk("rst_data", 64'(rf_wbck_data), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    step();

    // Single RF write
    drive(1, 32'h0000_00A5, 5'd3, 1, 0);
    step();
    drive(0, 32'd0, 5'd0, 0, 0);
    chk("t1_rf_valid", 64'(rf_wbck_valid), 64'd1);
    chk("t1_rf_idx", 64'(rf_wbck_idx), 64'd3);
    chk("t1_rf_data", 64'(rf_wbck_data), 64'hA5);
    step();
    chk("t1_cnt", 64'(wbck_cnt), 64'd0);
    chk("t1_idle", 64'(wbck_idle), 64'd1);

    // QWAIT timing write
    drive(1, 32'h0001_2345, 5'd9, 1, 1);
    step();
    drive(0, 32'd0, 5'd0, 0, 0);
    chk("t2_time_valid", 64'(time_wbck_valid), 64'd1);
    chk("t2_time_data", 64'(time_wbck_data), 64'h2345);
    chk("t2_rf_valid", 64'(rf_wbck_valid), 64'd0);
    step();

    // Back-pressure and full
    rf_wbck_ready = 0;
    drive(1, 32'd1, 5'd1, 1, 0); step();
    drive(1, 32'd2, 5'd1, 1, 0); step();
    drive(1, 32'd3, 5'd1, 1, 0);
    chk("t3_full_ready", 64'(wbck_i_ready), 64'd0);
    step();
    chk("t3_stall_cnt", 64'(wbck_cnt), 64'd2);
    rf_wbck_ready = 1;
    chk("t3_ret1", 64'(rf_wbck_data), 64'd1);
    step();
    chk("t3_ret2", 64'(rf_wbck_data), 64'd2);
    chk("t3_ready_again", 64'(wbck_i_ready), 64'd1);
    step();
    drive(0, 32'd0, 5'd0, 0, 0);
    chk("t3_ret3", 64'(rf_wbck_data), 64'd3);
    step();

    // DROP cases
    drive(1, 32'hDEAD, 5'd5, 0, 0); step();
    chk("t4_no_write1", 64'(rf_wbck_valid | time_wbck_valid), 64'd0);
    drive(1, 32'hBEEF, 5'd0, 1, 0); step();
    chk("t4_no_write2", 64'(rf_wbck_valid | time_wbck_valid), 64'd0);
    drive(1, 32'h77, 5'd7, 1, 0); step();
    drive(0, 32'd0, 5'd0, 0, 0);
    chk("t4_idx7_valid", 64'(rf_wbck_valid), 64'd1);
    chk("t4_idx7", 64'(rf_wbck_idx), 64'd7);
    step();

    // Ordering across targets
    time_wbck_ready = 0;
    drive(1, 32'h0000_0077, 5'd2, 1, 1); step();
    drive(1, 32'h0000_0044, 5'd4, 1, 0); step();
    drive(0, 32'd0, 5'd0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      chk("t5_rf_blocked", 64'(rf_wbck_valid), 64'd0);
      chk("t5_time_held", 64'(time_wbck_data), 64'h77);
      step();
    end
    time_wbck_ready = 1;
    step();
    chk("t5_rf_after", 64'(rf_wbck_valid), 64'd1);
    chk("t5_rf_idx", 64'(rf_wbck_idx), 64'd4);
    step();

    // Flush with two entries buffered
    rf_wbck_ready = 0;
    drive(1, 32'h11, 5'd1, 1, 0); step();
    drive(1, 32'h22, 5'd2, 1, 0); step();
    drive(1, 32'h33, 5'd3, 1, 0);
    chk("t6_cnt2", 64'(wbck_cnt), 64'd2);
    wbck_flush = 1; step();
    wbck_flush = 0;
    drive(0, 32'd0, 5'd0, 0, 0);
    chk("t6_cnt0", 64'(wbck_cnt), 64'd0);
    chk("t6_valids", 64'({rf_wbck_valid, time_wbck_valid}), 64'd0);
    step();

    // Mid-stall asynchronous reset
    drive(1, 32'h55, 5'd5, 1, 0); step();
    drive(1, 32'h66, 5'd6, 1, 1); step();
    drive(0, 32'd0, 5'd0, 0, 0);
    step();
    #1 rst_n = 1'b0;
    #1;
    chk("t7_rf_valid", 64'(rf_wbck_valid), 64'd0);
    chk("t7_time_valid", 64'(time_wbck_valid), 64'd0);
    chk("t7_cnt", 64'(wbck_cnt), 64'd0);
    chk("t7_idle", 64'(wbck_idle), 64'd1);
    chk("t7_ready", 64'(wbck_i_ready), 64'd1);
    chk("t7_data", 64'(rf_wbck_data), 64'd0);
    q.delete();
    rf_wbck_ready = 1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    step();
    chk("t7_no_write", 64'(rf_wbck_valid | time_wbck_valid), 64'd0);

    // Randomized traffic
    for (int c = 0; c < 600; c++) begin
      drive(1'($urandom_range(0, 1)), $urandom, 5'($urandom_range(0, 31)),
            1'($urandom_range(0, 7) != 0), 1'($urandom_range(0, 3) == 0));
      rf_wbck_ready   = ($urandom_range(0, 9) < 6);
      time_wbck_ready = ($urandom_range(0, 9) < 5);
      wbck_flush      = ($urandom_range(0, 31) == 0);
      step();
    end
    wbck_flush = 0;
    drive(0, 32'd0, 5'd0, 0, 0);
    rf_wbck_ready = 1; time_wbck_ready = 1;
    for (int c = 0; c < 4; c++) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
